ram_stream_reader: RTL and testbench



---
 rtl/ram_stream_pkg.sv | 17 +
 rtl/ram_rd_skid_fifo.sv | 51 +++++
 rtl/ram_stream_reader.sv | 108 ++++++++++
 tb/tb_ram_stream_reader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the RAM read-side streaming master.
package ram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int unsigned BUF_DEPTH = 2;

  // One extra bit so a full-depth burst length is representable.
  function automatic int len_width(input int add_bits);
    return add_bits + 1;
  endfunction

endpackage

// File: rtl/ram_rd_skid_fifo.sv
// Two-entry FIFO that absorbs RAM read latency against consumer backpressure.
module ram_rd_skid_fifo
  import ram_stream_pkg::*;
#(
  parameter int ram_width = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [ram_width-1:0] push_data,
  input  logic                 pop,
  output logic [ram_width-1:0] head_data,
  output logic [1:0]           occupancy
);

  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  logic [ram_width-1:0] mem [BUF_DEPTH];
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [1:0]           count;
  logic                 do_push;
  logic                 do_pop;

  assign do_pop    = pop && (count != 2'd0);
  assign do_push   = push && ((count < FULL) || do_pop);
  assign head_data = mem[rd_ptr];
  assign occupancy = count;

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Streams a burst of consecutive RAM words (address wraps at depth) onto a
// valid/ready output, hiding the RAM's one-cycle read latency.
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int ram_width = 16,
  parameter int add_size  = 3,
  parameter int len_size  = len_width(add_size)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [add_size-1:0]  base_add,
  input  logic [len_size-1:0]  length,
  output logic                 ram_read,
  output logic [add_size-1:0]  ram_read_add,
  input  logic [ram_width-1:0] ram_data,
  output logic [ram_width-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  state_t               state;
  logic [add_size-1:0]  addr;
  logic [len_size-1:0]  remaining;
  logic                 inflight;
  logic                 done_q;
  logic                 busy_q;
  logic [1:0]           occupancy;
  logic [2:0]           pending;
  logic                 pop;
  logic                 issue;
  logic                 accept;
  logic                 last_xfer;

  assign out_valid = (occupancy != 2'd0);
  assign pop       = out_valid && out_ready;
  assign pending   = {1'b0, occupancy} + {2'b00, inflight};
  // pending - pop < 2, rearranged to avoid an unsigned subtraction.
  assign issue     = (state == RUN) && (remaining != '0) &&
                     (pending < (3'd2 + {2'b00, pop}));
  assign accept    = (state == IDLE) && !busy_q && start;
  assign last_xfer = (state == FLUSH) && !inflight && (occupancy == 2'd1) && pop;

  assign ram_read     = issue;
  assign ram_read_add = addr;
  assign done         = done_q;
  assign busy         = busy_q;

  ram_rd_skid_fifo #(
    .ram_width(ram_width)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (ram_data),
    .pop       (pop),
    .head_data (out_data),
    .occupancy (occupancy)
  );

  // busy_q outlives the FSM by one cycle so it covers the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      inflight <= issue;
      if (done_q) busy_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (length != '0) begin
              addr      <= base_add;
              remaining <= length;
              busy_q    <= 1'b1;
              state     <= RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            addr      <= addr + add_size'(1);
            remaining <= remaining - len_size'(1);
            if (remaining == len_size'(1)) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (last_xfer) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench: behavioural RAM plus expected address/data queues.
module tb_ram_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  base_add = '0;
  logic [3:0]  length = '0;
  logic        ram_read;
  logic [2:0]  ram_read_add;
  logic [15:0] ram_data = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;

  logic [15:0] mem [8];
  int          exp_add[$];
  logic [15:0] exp_data[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          issued = 0;
  int          xfer = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  int          ready_mode = 0;
  int          ready_phase = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  logic        prev_done = 1'b0;

  ram_stream_reader #(
    .ram_width(16),
    .add_size (3),
    .len_size (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_add     (base_add),
    .length       (length),
    .ram_read     (ram_read),
    .ram_read_add (ram_read_add),
    .ram_data     (ram_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Registered-output RAM read port; data_out holds between reads.
  always @(posedge clk) if (ram_read) ram_data <= mem[ram_read_add];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Consumer readiness: 0 = always, 1 = 1,0,0 pattern, 2 = random (mostly high).
  initial forever begin
    @(posedge clk);
    #1;
    ready_phase++;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (ready_phase % 3 == 0);
      default: out_ready = ($urandom_range(3) != 0);
    endcase
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (ram_read) begin
        issued++;
        if (exp_add.size() == 0) check("unexpected_read", 32'd1, 32'd0);
        else check("rd_addr", 32'(ram_read_add), 32'(exp_add.pop_front()));
      end
      if (out_valid && out_ready) begin
        xfer++;
        if (exp_data.size() == 0) check("unexpected_word", 32'(out_data), 32'hdead);
        else check("out_data", 32'(out_data), 32'(exp_data.pop_front()));
      end
      if (ram_read) check("outstanding_le2", 32'(issued - xfer <= 2), 32'd1);
      if (done) begin
        done_cnt++;
        if (prev_done) check("done_single_cycle", 32'd1, 32'd0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_done  = done;
    end else begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end
  end

  task automatic wait_done(input logic busy_exp);
    int t = 0;
    while (!done && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("busy_at_done", 32'(busy), 32'(busy_exp));
      @(negedge clk);
      check("done_cleared", 32'(done), 32'd0);
      check("busy_after", 32'(busy), 32'd0);
      check("words_left", 32'(exp_data.size()), 32'd0);
    end
  endtask

  task automatic run_burst(input int base, input int len, input bit spurious);
    @(negedge clk);
    start    = 1'b1;
    base_add = 3'(base);
    length   = 4'(len);
    for (int k = 0; k < len; k++) begin
      exp_add.push_back((base + k) % 8);
      exp_data.push_back(mem[(base + k) % 8]);
    end
    exp_done++;
    @(negedge clk);
    start = 1'b0;
    if (len == 0) begin
      check("zero_done", 32'(done), 32'd1);
      check("zero_busy", 32'(busy), 32'd0);
      check("zero_no_read", 32'(ram_read), 32'd0);
      wait_done(1'b0);
    end else begin
      check("busy_cycle1", 32'(busy), 32'd1);
      check("read_cycle1", 32'(ram_read), 32'd1);
      @(negedge clk);
      check("valid_cycle2", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("valid_cycle3", 32'(out_valid), 32'd1);
      if (spurious) begin
        start    = 1'b1;
        base_add = 3'd1;
        length   = 4'd3;
        @(negedge clk);
        start = 1'b0;
      end
      wait_done(1'b1);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h1000 + 16'(i);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_read", 32'(ram_read), 32'd0);
    check("rst_addr", 32'(ram_read_add), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    ready_mode = 0; run_burst(2, 4, 1'b0);
    ready_mode = 0; run_burst(6, 4, 1'b0);
    ready_mode = 1; run_burst(0, 8, 1'b0);
    ready_mode = 0; run_burst(3, 0, 1'b0);
    ready_mode = 2; run_burst(0, 8, 1'b1);
    ready_mode = 0; run_burst(5, 8, 1'b0);

    // Reset mid-burst after about three words.
    begin
      int t = 0;
      ready_mode = 0;
      @(negedge clk);
      start = 1'b1; base_add = 3'd0; length = 4'd6;
      for (int k = 0; k < 6; k++) begin
        exp_add.push_back(k);
        exp_data.push_back(mem[k]);
      end
      @(negedge clk);
      start = 1'b0;
      while (xfer < 3 && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("reset_wait", 32'(t < 50), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_data", 32'(out_data), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_read", 32'(ram_read), 32'd0);
      check("mid_rst_addr", 32'(ram_read_add), 32'd0);
      exp_add.delete();
      exp_data.delete();
      issued = 0; xfer = 0; done_cnt = 0; exp_done = 0;
      @(negedge clk);
      rst_n = 1'b1;
      run_burst(0, 2, 1'b0);
      check("post_rst_words", 32'(xfer), 32'd2);
    end

    for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
    for (int n = 0; n < 20; n++) begin
      ready_mode = $urandom_range(2);
      run_burst($urandom_range(7), $urandom_range(8), 1'b0);
    end

    repeat (3) @(negedge clk);
    check("done_count", 32'(done_cnt), 32'(exp_done));
    check("reads_eq_words", 32'(issued), 32'(xfer));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
